// File: rtl/main_fsm.sv
// Multicycle processor control FSM: sequences fetch, decode and execute steps
// and drives Moore control outputs that are registered alongside the state.
module main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic [3:0] State
);

  // state    | meaning
  // FETCH    | read instruction at PC, PC <= PC + 4
  // DECODE   | read register file, pick instruction class
  // MEMADR   | compute load/store address
  // MEMRD    | read data memory
  // MEMWB    | write loaded data to register file
  // MEMWR    | write data memory
  // EXECUTER | ALU op with register operand
  // EXECUTEI | ALU op with immediate operand
  // ALUWB    | write ALU result to register file
  // BRANCH   | compute branch target, conditional PC write
  // UNKNOWN  | undefined instruction, no side effects
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_t;

  // {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,NextPC,RegW,MemW,Branch,ALUOp}
  localparam logic [12:0] CTRL_FETCH    = 13'b1_0_01_10_10_1_0_0_0_0;
  localparam logic [12:0] CTRL_DECODE   = 13'b0_0_01_10_10_0_0_0_0_0;
  localparam logic [12:0] CTRL_MEMADR   = 13'b0_0_00_01_00_0_0_0_0_0;
  localparam logic [12:0] CTRL_MEMRD    = 13'b0_1_00_00_00_0_0_0_0_0;
  localparam logic [12:0] CTRL_MEMWB    = 13'b0_0_00_00_01_0_1_0_0_0;
  localparam logic [12:0] CTRL_MEMWR    = 13'b0_1_00_00_00_0_0_1_0_0;
  localparam logic [12:0] CTRL_EXECUTER = 13'b0_0_00_00_00_0_0_0_0_1;
  localparam logic [12:0] CTRL_EXECUTEI = 13'b0_0_00_01_00_0_0_0_0_1;
  localparam logic [12:0] CTRL_ALUWB    = 13'b0_0_00_00_00_0_1_0_0_0;
  localparam logic [12:0] CTRL_BRANCH   = 13'b0_0_00_01_10_0_0_0_1_0;
  localparam logic [12:0] CTRL_NONE     = 13'b0;

  state_t      state;
  logic [12:0] ctrl;
  logic        funct_unused;

  assign funct_unused = ^Funct[4:1];

  function automatic state_t next_state(input state_t s, input logic [1:0] op,
                                        input logic imm, input logic load);
    case (s)
      FETCH:    next_state = DECODE;
      DECODE: begin
        case (op)
          2'b00:   next_state = imm ? EXECUTEI : EXECUTER;
          2'b01:   next_state = MEMADR;
          2'b10:   next_state = BRANCH;
          default: next_state = UNKNOWN;
        endcase
      end
      MEMADR:   next_state = load ? MEMRD : MEMWR;
      MEMRD:    next_state = MEMWB;
      EXECUTER: next_state = ALUWB;
      EXECUTEI: next_state = ALUWB;
      default:  next_state = FETCH;
    endcase
  endfunction

  function automatic logic [12:0] ctrl_of(input state_t s);
    case (s)
      FETCH:    ctrl_of = CTRL_FETCH;
      DECODE:   ctrl_of = CTRL_DECODE;
      MEMADR:   ctrl_of = CTRL_MEMADR;
      MEMRD:    ctrl_of = CTRL_MEMRD;
      MEMWB:    ctrl_of = CTRL_MEMWB;
      MEMWR:    ctrl_of = CTRL_MEMWR;
      EXECUTER: ctrl_of = CTRL_EXECUTER;
      EXECUTEI: ctrl_of = CTRL_EXECUTEI;
      ALUWB:    ctrl_of = CTRL_ALUWB;
      BRANCH:   ctrl_of = CTRL_BRANCH;
      default:  ctrl_of = CTRL_NONE;
    endcase
  endfunction

  // Outputs are registered from the next state so they always match State.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      ctrl  <= CTRL_FETCH;
    end else begin
      state <= next_state(state, Op, Funct[5], Funct[0]);
      ctrl  <= ctrl_of(next_state(state, Op, Funct[5], Funct[0]));
    end
  end

  assign {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
          NextPC, RegW, MemW, Branch, ALUOp} = ctrl;
  assign State = state;

endmodule
